// File: rtl/hsi_vector_multicore_csr.sv
// OBI register file that configures and monitors NUM_CORES HSI vector cores.
// Per-core run state lives in an array of core slices; the top decodes the bus and muxes read data.

module hsi_vector_multicore_csr_core #(
  parameter int ERR_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 clr_i,
  input  logic                 w1c_i,
  input  logic                 pixel_done_i,
  input  logic [ERR_WIDTH-1:0] error_code_i,
  output logic                 start_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ERR_WIDTH-1:0] err_code_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);
  logic                 start_q, start_d, busy_q, busy_d, done_q, done_d;
  logic [ERR_WIDTH-1:0] errc_q, errc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Completion is applied last so it wins over a same-cycle W1C or counter clear.
  always_comb begin
    start_d = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    errc_d  = errc_q;
    cnt_d   = cnt_q;
    if (start_i && !busy_q) begin
      start_d = 1'b1;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      errc_d  = '0;
    end
    if (w1c_i) done_d = 1'b0;
    if (clr_i) cnt_d = '0;
    if (pixel_done_i) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      errc_d = error_code_i;
      if (cnt_d != {CNT_WIDTH{1'b1}}) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      errc_q  <= '0;
      cnt_q   <= '0;
    end else begin
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      errc_q  <= errc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_o    = start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_code_o = errc_q;
  assign cnt_o      = cnt_q;
endmodule

module hsi_vector_multicore_csr #(
  parameter int NUM_CORES       = 4,
  parameter int OP_CODE_WIDTH   = 8,
  parameter int NUM_BANDS_WIDTH = 8,
  parameter int ERR_WIDTH       = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_i,
  input  logic                                 we_i,
  input  logic [3:0]                           be_i,
  input  logic [31:0]                          addr_i,
  input  logic [31:0]                          wdata_i,
  output logic                                 gnt_o,
  output logic                                 rvalid_o,
  output logic [31:0]                          rdata_o,
  output logic                                 err_o,
  output logic [NUM_CORES*OP_CODE_WIDTH-1:0]   op_code_o,
  output logic [NUM_CORES*NUM_BANDS_WIDTH-1:0] num_bands_o,
  output logic [NUM_CORES-1:0]                 start_o,
  input  logic [NUM_CORES-1:0]                 pixel_done_i,
  input  logic [NUM_CORES*ERR_WIDTH-1:0]       error_code_i,
  output logic                                 irq_o
);
  logic [NUM_CORES-1:0][OP_CODE_WIDTH-1:0]   op_code_q, op_code_d;
  logic [NUM_CORES-1:0][NUM_BANDS_WIDTH-1:0] num_bands_q, num_bands_d;
  logic [NUM_CORES-1:0]                      irq_en_q, irq_en_d;
  logic                                      rvalid_q, rvalid_d, err_q, err_d, irq_q, irq_d;
  logic [31:0]                               rdata_q, rdata_d, rd_val;
  logic                                      dec_err, start_err, wr;
  logic [NUM_CORES-1:0]                      start_wr, clr_wr, w1c_wr, busy, done;
  logic [NUM_CORES-1:0][ERR_WIDTH-1:0]       errc;
  logic [NUM_CORES-1:0][CNT_WIDTH-1:0]       cnt;
  logic [9:0]                                a;
  logic                                      unused_addr;

  assign a           = addr_i[9:0];
  assign unused_addr = ^addr_i[31:10];
  assign wr          = req_i & we_i;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    hsi_vector_multicore_csr_core #(.ERR_WIDTH(ERR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_core (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_wr[g]),
      .clr_i        (clr_wr[g]),
      .w1c_i        (w1c_wr[g]),
      .pixel_done_i (pixel_done_i[g]),
      .error_code_i (error_code_i[g*ERR_WIDTH +: ERR_WIDTH]),
      .start_o      (start_o[g]),
      .busy_o       (busy[g]),
      .done_o       (done[g]),
      .err_code_o   (errc[g]),
      .cnt_o        (cnt[g])
    );
  end

  // Only a fully decoded, aligned hit clears dec_err; every state change is gated by it.
  always_comb begin
    dec_err     = 1'b1;
    start_err   = 1'b0;
    rd_val      = '0;
    start_wr    = '0;
    clr_wr      = '0;
    w1c_wr      = '0;
    op_code_d   = op_code_q;
    num_bands_d = num_bands_q;
    irq_en_d    = irq_en_q;
    if (a[1:0] == 2'b00) begin
      case (a[9:8])
        2'd0: for (int n = 0; n < NUM_CORES; n++) begin
          if (a[7:4] == n[3:0]) begin
            dec_err = 1'b0;
            case (a[3:2])
              2'd0: begin
                rd_val = 32'(op_code_q[n]);
                if (wr) op_code_d[n] = OP_CODE_WIDTH'(be_merge(32'(op_code_q[n]), wdata_i, be_i));
              end
              2'd1: begin
                rd_val = 32'(num_bands_q[n]);
                if (wr) num_bands_d[n] = NUM_BANDS_WIDTH'(be_merge(32'(num_bands_q[n]), wdata_i, be_i));
              end
              2'd2: if (wr && be_i[0]) begin
                start_wr[n] = wdata_i[0];
                clr_wr[n]   = wdata_i[1];
                start_err   = wdata_i[0] & busy[n];
              end
              default: begin
                rd_val = 32'({errc[n], busy[n], done[n]});
                if (wr && be_i[0]) w1c_wr[n] = wdata_i[0];
              end
            endcase
          end
        end
        2'd1: begin
          if (a[7:0] == 8'h00) begin
            dec_err = 1'b0;
            rd_val  = 32'(irq_en_q);
            if (wr) irq_en_d = NUM_CORES'(be_merge(32'(irq_en_q), wdata_i, be_i));
          end else if (a[7:0] == 8'h04) begin
            dec_err = 1'b0;
            rd_val  = 32'(done & irq_en_q);
          end
        end
        2'd2: for (int n = 0; n < NUM_CORES; n++) begin
          if (a[7:2] == n[5:0]) begin
            dec_err = 1'b0;
            rd_val  = 32'(cnt[n]);
          end
        end
        default: ;
      endcase
    end
    if (dec_err) begin
      start_wr    = '0;
      clr_wr      = '0;
      w1c_wr      = '0;
      op_code_d   = op_code_q;
      num_bands_d = num_bands_q;
      irq_en_d    = irq_en_q;
    end
    rvalid_d = req_i;
    rdata_d  = (req_i && !we_i && !dec_err) ? rd_val : '0;
    err_d    = req_i & (dec_err | start_err);
    irq_d    = |(done & irq_en_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_code_q   <= '0;
      num_bands_q <= '0;
      irq_en_q    <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      op_code_q   <= op_code_d;
      num_bands_q <= num_bands_d;
      irq_en_q    <= irq_en_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
    end
  end

  assign gnt_o       = req_i & rst_ni;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign irq_o       = irq_q;
  assign op_code_o   = op_code_q;
  assign num_bands_o = num_bands_q;
endmodule
